// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and counter sizing for the PLL lock sequencer
package pll_seq_pkg;
  typedef logic [2:0] state_t;
  localparam state_t ST_PLL_RST   = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_STABLE    = 3'd2;
  localparam state_t ST_RELEASE   = 3'd3;
  localparam state_t ST_RUN       = 3'd4;
  localparam state_t ST_FAULT     = 3'd5;
  // Bits needed to count 0..max-1 over the largest cycle parameter
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_s1;
  logic r_s2;
  // Shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  assign o_q = r_s2;
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: resets a PLL, waits for stable lock, then staggers channel reset releases
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_CH              = 4,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int STAGGER_CYCLES      = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              sw_reset,
  output logic              pll_rst,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state,
  output logic [7:0]        relock_count
);
  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                NUM_CH * STAGGER_CYCLES);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'((NUM_CH - 1) * STAGGER_CYCLES);
  localparam logic [RW-1:0] RET_LIMIT = RW'(MAX_RETRIES);
  logic              w_locked_s;
  state_t            r_state;
  state_t            w_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [RW-1:0]     r_retries;
  logic [RW-1:0]     w_ret_nxt;
  logic [7:0]        r_relock;
  logic [7:0]        w_relock_nxt;
  logic [NUM_CH-1:0] w_ch_nxt;
  logic              r_pll_rst;
  logic [NUM_CH-1:0] r_ch_rst_n;
  logic              r_ready;
  logic              r_fault;

  sync_2ff u_sync_locked (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (locked),
    .o_q     (w_locked_s)
  );

  // Next-state, counter, retry and relock bookkeeping; sw_reset overrides everything
  always_comb begin
    w_nxt        = r_state;
    w_cnt_nxt    = r_cnt;
    w_ret_nxt    = r_retries;
    w_relock_nxt = r_relock;
    if (sw_reset) begin
      w_nxt     = ST_PLL_RST;
      w_cnt_nxt = '0;
      w_ret_nxt = '0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          w_nxt     = (r_cnt == RST_LAST) ? ST_WAIT_LOCK : ST_PLL_RST;
          w_cnt_nxt = (r_cnt == RST_LAST) ? '0 : r_cnt + 1'b1;
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_nxt     = ST_STABLE;
            w_cnt_nxt = '0;
          end else if (r_cnt == TO_LAST) begin
            w_cnt_nxt = '0;
            w_nxt     = (r_retries == RET_LIMIT) ? ST_FAULT : ST_PLL_RST;
            w_ret_nxt = (r_retries == RET_LIMIT) ? r_retries : r_retries + 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          w_nxt     = !w_locked_s ? ST_WAIT_LOCK : (r_cnt == STB_LAST) ? ST_RELEASE : ST_STABLE;
          w_cnt_nxt = (!w_locked_s || r_cnt == STB_LAST) ? '0 : r_cnt + 1'b1;
        end
        ST_RELEASE, ST_RUN: begin
          if (!w_locked_s) begin
            w_nxt        = ST_WAIT_LOCK;
            w_cnt_nxt    = '0;
            w_relock_nxt = (r_relock == 8'hff) ? r_relock : r_relock + 8'd1;
          end else if (r_state == ST_RELEASE) begin
            w_nxt     = (r_cnt == REL_LAST) ? ST_RUN : ST_RELEASE;
            w_cnt_nxt = (r_cnt == REL_LAST) ? '0 : r_cnt + 1'b1;
          end
        end
        ST_FAULT: w_nxt = ST_FAULT;
        default: begin
          w_nxt     = ST_PLL_RST;
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_ch_nxt[i] = (w_nxt == ST_RUN) ||
                         ((w_nxt == ST_RELEASE) && (int'(w_cnt_nxt) >= i * STAGGER_CYCLES));
  end

  // Register state and decode every output from the next state so outputs are flop-driven
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= ST_PLL_RST;
      r_cnt      <= '0;
      r_retries  <= '0;
      r_relock   <= '0;
      r_pll_rst  <= 1'b1;
      r_ch_rst_n <= '0;
      r_ready    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_retries  <= w_ret_nxt;
      r_relock   <= w_relock_nxt;
      r_pll_rst  <= (w_nxt == ST_PLL_RST) || (w_nxt == ST_FAULT);
      r_ch_rst_n <= w_ch_nxt;
      r_ready    <= (w_nxt == ST_RUN);
      r_fault    <= (w_nxt == ST_FAULT);
    end

  assign state        = r_state;
  assign pll_rst      = r_pll_rst;
  assign ch_rst_n     = r_ch_rst_n;
  assign ready        = r_ready;
  assign fault        = r_fault;
  assign relock_count = r_relock;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios for the PLL lock sequencer
module tb_pll_lock_sequencer;
  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       sw_reset = 1'b0;
  logic       pll_rst;
  logic [2:0] ch_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [7:0] relock_count;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .NUM_CH(3), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32), .STAGGER_CYCLES(4), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .locked(locked), .sw_reset(sw_reset),
    .pll_rst(pll_rst), .ch_rst_n(ch_rst_n), .ready(ready), .fault(fault),
    .state(state), .relock_count(relock_count)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic wait_st(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (state !== s && n < budget) begin
      tick(1);
      n++;
    end
    if (state !== s) n = -1;
  endtask

  task automatic test_reset();
    tick(2);
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL rst_pll_rst got=%b exp=1", pll_rst); end
    n_checks++; if (ch_rst_n !== 3'b000) begin n_fail++; $display("FAIL rst_ch got=%b exp=000", ch_rst_n); end
    n_checks++; if (ready !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL rst_rdy_flt got=%b%b exp=00", ready, fault); end
    n_checks++; if (relock_count !== 8'd0) begin n_fail++; $display("FAIL rst_relock got=%0d exp=0", relock_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int n;
    logic [2:0] e;
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      n++;
      tick(1);
    end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL nom_pll_rst_width got=%0d exp=4", n); end
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL nom_wait_state got=%0d exp=1", state); end
    tick(6);
    locked = 1'b1;
    wait_st(3'd2, 20, n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL nom_to_stable got=%0d exp=3", n); end
    wait_st(3'd3, 20, n);
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL nom_to_release got=%0d exp=8", n); end
    n_checks++; if (ch_rst_n !== 3'b001) begin n_fail++; $display("FAIL nom_rel_entry_ch got=%b exp=001", ch_rst_n); end
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      e = (k < 4) ? 3'b001 : (k < 8) ? 3'b011 : 3'b111;
      n_checks++; if (ch_rst_n !== e || state !== 3'd3) begin n_fail++; $display("FAIL nom_rel_ch k=%0d got=%b/%0d exp=%b/3", k, ch_rst_n, state, e); end
    end
    tick(1);
    n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL nom_run_state got=%0d exp=4", state); end
    n_checks++; if (ready !== 1'b1 || ch_rst_n !== 3'b111 || pll_rst !== 1'b0) begin n_fail++; $display("FAIL nom_run_out got=%b/%b/%b exp=1/111/0", ready, ch_rst_n, pll_rst); end
  endtask

  task automatic test_run_loss();
    int n;
    locked = 1'b0;
    tick(2);
    n_checks++; if (state !== 3'd4 || ch_rst_n !== 3'b111) begin n_fail++; $display("FAIL loss_pre got=%0d/%b exp=4/111", state, ch_rst_n); end
    tick(1);
    n_checks++; if (state !== 3'd1 || ch_rst_n !== 3'b000) begin n_fail++; $display("FAIL loss_state_ch got=%0d/%b exp=1/000", state, ch_rst_n); end
    n_checks++; if (relock_count !== 8'd1) begin n_fail++; $display("FAIL loss_relock got=%0d exp=1", relock_count); end
    n_checks++; if (pll_rst !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL loss_pll_rdy got=%b%b exp=00", pll_rst, ready); end
    locked = 1'b1;
    wait_st(3'd2, 20, n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL loss_to_stable got=%0d exp=3", n); end
    wait_st(3'd3, 20, n);
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL loss_to_release got=%0d exp=8", n); end
    wait_st(3'd4, 20, n);
    n_checks++; if (n !== 9) begin n_fail++; $display("FAIL loss_to_run got=%0d exp=9", n); end
    n_checks++; if (ready !== 1'b1 || relock_count !== 8'd1) begin n_fail++; $display("FAIL loss_rerun got=%b/%0d exp=1/1", ready, relock_count); end
  endtask

  task automatic test_glitch();
    int n;
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    n_checks++; if (state !== 3'd0 || pll_rst !== 1'b1 || ch_rst_n !== 3'b000) begin n_fail++; $display("FAIL sw_run got=%0d/%b/%b exp=0/1/000", state, pll_rst, ch_rst_n); end
    n_checks++; if (relock_count !== 8'd1 || ready !== 1'b0) begin n_fail++; $display("FAIL sw_relock got=%0d/%b exp=1/0", relock_count, ready); end
    wait_st(3'd2, 20, n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL gl_to_stable got=%0d exp=5", n); end
    tick(2);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    wait_st(3'd1, 10, n);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL gl_to_wait got=%0d exp=2", n); end
    wait_st(3'd2, 10, n);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL gl_restable got=%0d exp=1", n); end
    wait_st(3'd3, 20, n);
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL gl_to_release got=%0d exp=8", n); end
    wait_st(3'd4, 20, n);
    n_checks++; if (n !== 9) begin n_fail++; $display("FAIL gl_to_run got=%0d exp=9", n); end
  endtask

  task automatic test_sw_vs_loss();
    locked = 1'b0;
    tick(2);
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL swl_state got=%0d exp=0", state); end
    n_checks++; if (relock_count !== 8'd1) begin n_fail++; $display("FAIL swl_relock got=%0d exp=1", relock_count); end
    n_checks++; if (pll_rst !== 1'b1 || ch_rst_n !== 3'b000) begin n_fail++; $display("FAIL swl_out got=%b/%b exp=1/000", pll_rst, ch_rst_n); end
  endtask

  task automatic test_timeout_fault();
    int n;
    int pulses;
    int hi;
    logic prev;
    for (int pass = 0; pass < 2; pass++) begin
      n = 0;
      pulses = 0;
      hi = 0;
      prev = 1'b0;
      while (fault !== 1'b1 && n < 300) begin
        if (pll_rst === 1'b1 && !prev) pulses++;
        if (pll_rst === 1'b1) hi++;
        prev = pll_rst;
        tick(1);
        n++;
      end
      n_checks++; if (n !== 108) begin n_fail++; $display("FAIL to_cycles pass=%0d got=%0d exp=108", pass, n); end
      n_checks++; if (pulses !== 3 || hi !== 12) begin n_fail++; $display("FAIL to_pulses pass=%0d got=%0d/%0d exp=3/12", pass, pulses, hi); end
      n_checks++; if (state !== 3'd5 || pll_rst !== 1'b1 || ch_rst_n !== 3'b000 || ready !== 1'b0) begin n_fail++; $display("FAIL fault_out got=%0d/%b/%b/%b exp=5/1/000/0", state, pll_rst, ch_rst_n, ready); end
      tick(5);
      n_checks++; if (state !== 3'd5 || fault !== 1'b1) begin n_fail++; $display("FAIL fault_hold got=%0d/%b exp=5/1", state, fault); end
      sw_reset = 1'b1;
      tick(1);
      sw_reset = 1'b0;
      n_checks++; if (state !== 3'd0 || fault !== 1'b0 || pll_rst !== 1'b1) begin n_fail++; $display("FAIL fault_exit got=%0d/%b/%b exp=0/0/1", state, fault, pll_rst); end
    end
  endtask

  task automatic test_async_reset();
    int n;
    locked = 1'b1;
    wait_st(3'd3, 40, n);
    n_checks++; if (n !== 13) begin n_fail++; $display("FAIL ar_to_release got=%0d exp=13", n); end
    tick(5);
    n_checks++; if (ch_rst_n !== 3'b011) begin n_fail++; $display("FAIL ar_mid_ch got=%b exp=011", ch_rst_n); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (state !== 3'd0 || pll_rst !== 1'b1 || ch_rst_n !== 3'b000) begin n_fail++; $display("FAIL ar_out got=%0d/%b/%b exp=0/1/000", state, pll_rst, ch_rst_n); end
    n_checks++; if (ready !== 1'b0 || fault !== 1'b0 || relock_count !== 8'd0) begin n_fail++; $display("FAIL ar_misc got=%b/%b/%0d exp=0/0/0", ready, fault, relock_count); end
    tick(2);
    rst_n = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      n++;
      tick(1);
    end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL ar_pll_rst_width got=%0d exp=4", n); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_run_loss();
    test_glitch();
    test_sw_vs_loss();
    test_timeout_fault();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after 200000 time units");
    $fatal(1);
  end
endmodule
